// File: rtl/fpsr_pkg.sv
// Shared definitions for the first-person-second-row game: lecture FSM
// state encoding and the default timing constants.
package fpsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // 2^26 cycles at 100 MHz is roughly 0.67 s per game minute
  localparam int unsigned DEF_TICK_CYCLES = 67_108_864;
  localparam int unsigned DEF_MAX_MIN     = 75;
  localparam int unsigned DEF_QUIZ_PERIOD = 15;

endpackage

// File: rtl/bcd_digit_counter.sv
// One decimal digit: counts 0..9 on enable, carries out on the 9->0 wrap.
module bcd_digit_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] digit,
  output logic       carry
);

  // carry is combinational so the next digit advances on the same edge
  assign carry = en && (digit == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (en) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/lecture_timer.sv
// Lecture clock: prescales Clk into game minutes, counts them in binary and
// BCD, freezes on pause and flags quiz-due and end-of-lecture events.
module lecture_timer
  import fpsr_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int unsigned MAX_MIN     = DEF_MAX_MIN,
  parameter int unsigned QUIZ_PERIOD = DEF_QUIZ_PERIOD
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       clear,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] minutes,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic       tick,
  output logic       quiz_due,
  output logic       running,
  output logic       class_over,
  output state_e     fsm_state
);

  localparam int              PW         = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0]   PRESC_TERM = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [7:0]      LAST_MIN   = 8'(MAX_MIN - 1);
  localparam logic [6:0]      QUIZ_LAST  = 7'(QUIZ_PERIOD - 1);

  state_e        state;
  state_e        state_next;
  logic [PW-1:0] presc;
  logic [6:0]    quiz_cnt;
  logic          count_en;
  logic          inc;
  logic          last_min;
  logic          ones_carry;
  logic          tens_carry;

  // The resume edge out of PAUSE counts too, so a P-cycle pause shifts
  // every later tick by exactly P cycles.
  assign count_en = !clear && !pause && (state == ST_RUN || state == ST_PAUSE);
  assign inc      = count_en && (presc == PRESC_TERM);
  assign last_min = (minutes == LAST_MIN);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_next = ST_RUN;
        end
        ST_RUN, ST_PAUSE: begin
          if (pause)                 state_next = ST_PAUSE;
          else if (inc && last_min)  state_next = ST_DONE;
          else                       state_next = ST_RUN;
        end
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    running    = 1'b0;
    class_over = 1'b0;
    case (state)
      ST_RUN:  running    = 1'b1;
      ST_DONE: class_over = 1'b1;
      default: ;
    endcase
  end

  assign fsm_state = state;

  // ---------------- prescaler, minute and quiz counters ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc    <= '0;
      minutes  <= 8'd0;
      quiz_cnt <= 7'd0;
      tick     <= 1'b0;
      quiz_due <= 1'b0;
    end else if (clear) begin
      presc    <= '0;
      minutes  <= 8'd0;
      quiz_cnt <= 7'd0;
      tick     <= 1'b0;
      quiz_due <= 1'b0;
    end else begin
      tick     <= inc;
      // reaching the last minute ends the lecture instead of calling a quiz
      quiz_due <= inc && (quiz_cnt == QUIZ_LAST) && !last_min;
      if (count_en) begin
        presc <= (presc == PRESC_TERM) ? '0 : presc + PRESC_ONE;
      end
      if (inc) begin
        minutes  <= minutes + 8'd1;
        quiz_cnt <= (quiz_cnt == QUIZ_LAST) ? 7'd0 : quiz_cnt + 7'd1;
      end
    end
  end

  // ---------------- BCD digits, chained ones -> tens ----------------
  bcd_digit_counter u_ones (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (clear),
    .en    (inc),
    .digit (min_ones),
    .carry (ones_carry)
  );

  bcd_digit_counter u_tens (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (clear),
    .en    (ones_carry),
    .digit (min_tens),
    .carry (tens_carry)
  );

  // minutes never pass 99, so the tens carry has no consumer
  logic unused_tens_carry;
  assign unused_tens_carry = tens_carry;

endmodule

// File: tb/tb_lecture_timer.sv
// Bench for lecture_timer: directed scenarios plus random control traffic,
// checked every cycle against an elapsed-time reference model.
module tb_lecture_timer;
  import fpsr_pkg::*;

  localparam int T  = 4;
  localparam int MX = 6;
  localparam int QP = 3;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_PAUSE = 2;
  localparam int P_DONE  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear, start, pause;
  logic [7:0] minutes;
  logic [3:0] min_tens, min_ones;
  logic       tick, quiz_due, running, class_over;
  state_e     st1;

  logic       rst2_n, clear2, start2, pause2;
  logic [7:0] minutes2;
  logic [3:0] tens2, ones2;
  logic       tick2, quiz2, running2, over2;
  state_e     st2;

  lecture_timer #(.TICK_CYCLES(T), .MAX_MIN(MX), .QUIZ_PERIOD(QP)) dut (
    .Clk(clk), .Reset_n(rst_n), .clear(clear), .start(start), .pause(pause),
    .minutes(minutes), .min_tens(min_tens), .min_ones(min_ones),
    .tick(tick), .quiz_due(quiz_due), .running(running),
    .class_over(class_over), .fsm_state(st1)
  );

  lecture_timer #(.TICK_CYCLES(2), .MAX_MIN(12), .QUIZ_PERIOD(QP)) dut_bcd (
    .Clk(clk), .Reset_n(rst2_n), .clear(clear2), .start(start2), .pause(pause2),
    .minutes(minutes2), .min_tens(tens2), .min_ones(ones2),
    .tick(tick2), .quiz_due(quiz2), .running(running2),
    .class_over(over2), .fsm_state(st2)
  );

  int    errors = 0;
  int    checks = 0;
  string scen   = "init";

  // ---------------- reference model ----------------
  // minutes = completed game minutes of un-paused running time, capped
  int   m_phase, m_active, m_min;
  logic m_tick, m_quiz;

  task automatic model_reset();
    m_phase = P_IDLE; m_active = 0; m_min = 0; m_tick = 1'b0; m_quiz = 1'b0;
  endtask

  task automatic model_step();
    int prev;
    prev   = m_min;
    m_tick = 1'b0;
    m_quiz = 1'b0;
    if (!rst_n) return;
    if (clear) begin
      m_phase = P_IDLE; m_active = 0; m_min = 0;
      return;
    end
    case (m_phase)
      P_IDLE: if (start) m_phase = P_RUN;
      P_RUN, P_PAUSE: begin
        if (pause) m_phase = P_PAUSE;
        else begin
          m_active++;
          m_min   = m_active / T;
          m_phase = (m_min >= MX) ? P_DONE : P_RUN;
        end
      end
      default: ;
    endcase
    m_tick = (m_min != prev);
    m_quiz = m_tick && (m_min % QP == 0) && (m_min != MX);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0d expected %0d", scen, tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("minutes",    32'(minutes),    32'(m_min));
    chk("min_tens",   32'(min_tens),   32'(m_min / 10));
    chk("min_ones",   32'(min_ones),   32'(m_min % 10));
    chk("tick",       32'(tick),       32'(m_tick));
    chk("quiz_due",   32'(quiz_due),   32'(m_quiz));
    chk("running",    32'(running),    32'(m_phase == P_RUN));
    chk("class_over", 32'(class_over), 32'(m_phase == P_DONE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cycle(); clear = 1'b0;
  endtask

  // cycles until the DUT ticks, -1 if it never does within the budget
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      cycle();
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b1; clear = 1'b0; start = 1'b0; pause = 1'b0;
    rst2_n = 1'b1; clear2 = 1'b0; start2 = 1'b0; pause2 = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b0; rst2_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    scen = "reset";
    check_all();
    rst_n = 1'b1; rst2_n = 1'b1;

    // start latency and tick recurrence
    scen = "start";
    pulse_start();
    wait_tick(n);
    chk("first_tick_latency", 32'(n), 32'd4);
    wait_tick(n);
    chk("tick_period", 32'(n), 32'd4);

    // run to the end of the lecture, then idle
    scen = "run_to_done";
    cycles(4 * (MX - 2));
    chk("done_minutes", 32'(minutes), 32'(MX));
    chk("done_flag", 32'(class_over), 32'd1);
    cycles(20);
    chk("done_hold_minutes", 32'(minutes), 32'(MX));

    // clear while in DONE
    scen = "clear_done";
    do_clear();
    chk("clear_done_minutes", 32'(minutes), 32'd0);
    chk("clear_done_over", 32'(class_over), 32'd0);

    // pause for 10 cycles with the prescaler at 2
    scen = "pause_mid";
    pulse_start();
    cycles(2);
    pause = 1'b1;
    cycles(10);
    pause = 1'b0;
    wait_tick(n);
    chk("pause_tick_delay", 32'(10 + n), 32'd12);

    // pause on the terminal-count cycle
    scen = "pause_term";
    cycles(3);
    pause = 1'b1;
    cycle();
    chk("pause_term_no_tick", 32'(tick), 32'd0);
    pause = 1'b0;
    wait_tick(n);
    chk("pause_term_release", 32'(n), 32'd1);

    // clear together with start while running
    scen = "clear_start";
    clear = 1'b1; start = 1'b1;
    cycle();
    clear = 1'b0; start = 1'b0;
    chk("clear_start_running", 32'(running), 32'd0);
    chk("clear_start_minutes", 32'(minutes), 32'd0);
    cycles(6);

    // asynchronous reset mid-minute at minutes=4
    scen = "async_reset";
    pulse_start();
    cycles(4 * 4 + 1);
    chk("pre_reset_minutes", 32'(minutes), 32'd4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle();
    rst_n = 1'b1;
    pulse_start();
    wait_tick(n);
    chk("post_reset_latency", 32'(n), 32'd4);

    // random control traffic
    scen = "random";
    for (int i = 0; i < 400; i++) begin
      clear = ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 99) < 10);
      pause = ($urandom_range(0, 99) < 25);
      cycle();
    end
    clear = 1'b0; start = 1'b0; pause = 1'b0;
    cycle();

    // BCD carry on the second instance (2 cycles per minute, ends at 12)
    scen = "bcd";
    start2 = 1'b1; cycle(); start2 = 1'b0;
    cycles(18);
    chk("bcd9_minutes", 32'(minutes2), 32'd9);
    chk("bcd9_tens", 32'(tens2), 32'd0);
    chk("bcd9_ones", 32'(ones2), 32'd9);
    cycles(2);
    chk("bcd10_minutes", 32'(minutes2), 32'd10);
    chk("bcd10_tens", 32'(tens2), 32'd1);
    chk("bcd10_ones", 32'(ones2), 32'd0);
    cycles(4);
    chk("bcd12_tens", 32'(tens2), 32'd1);
    chk("bcd12_ones", 32'(ones2), 32'd2);
    chk("bcd12_over", 32'(over2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lecture_timer.md
# lecture_timer

Lecture clock for the first-person-second-row game. Divides the system clock into game "minutes", keeps the elapsed-minute count in binary and BCD, freezes while a quiz is in progress, and flags quiz-due and end-of-lecture events. Sits upstream of the game FSM, driving its `minutes` input, and feeds the two minute digits of the seven-segment scan logic.

## Interface
- `TICK_CYCLES`, 67_108_864: Clk cycles per game minute. Must be ≥ 2.
- `MAX_MIN`, 75: minute count at which the lecture ends. Range 1..99.
- `QUIZ_PERIOD`, 15: minutes between quiz requests. Range 1..99.

- `Clk`  in  1  system clock, 100 MHz
- `Reset_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous clear, driven by `q_INI`
- `start`  in  1  one-cycle pulse that starts the lecture, from the debounced BtnC
- `pause`  in  1  level; freezes timing while high, driven by `q_QUIZ`
- `minutes`  out  8  elapsed minutes, binary
- `min_tens`  out  4  elapsed minutes, BCD tens digit
- `min_ones`  out  4  elapsed minutes, BCD ones digit
- `tick`  out  1  one-cycle pulse on every minute increment
- `quiz_due`  out  1  one-cycle pulse when a quiz is due
- `running`  out  1  high in the RUN state
- `class_over`  out  1  high in the DONE state

## Operation
The block is a four-state FSM: IDLE, RUN, PAUSE, DONE.

- **Reset** (`Reset_n` low): state = IDLE; prescaler, `minutes`, BCD digits and quiz counter = 0; all outputs = 0.
- **Clear priority:** `clear` high forces IDLE on the next edge from any state, with the same zeroing as reset. It overrides `start`, `pause` and a terminal prescaler count in the same cycle.
- **IDLE:** counters hold 0. `start` moves the FSM to RUN, and the prescaler starts from 0.
- **RUN:**
  - With `pause` low, the prescaler increments every cycle.
  - At `TICK_CYCLES-1` the prescaler wraps to 0. On the same edge `minutes` increments, the BCD digits increment and `tick` pulses.
  - `pause` high in RUN moves the FSM to PAUSE with no increment that cycle. This holds even when the prescaler is at its terminal count.
- **PAUSE:** prescaler, `minutes`, BCD digits and quiz counter all hold their values. `pause` low returns to RUN, and the prescaler resumes from its held value; there is no restart.
- **DONE:** entered on the edge where `minutes` becomes `MAX_MIN`. In DONE the counters hold, `pause` and `start` are ignored, and only `clear` or reset exits.
- **start outside IDLE:** ignored.
- **BCD rule:** the ones digit wraps 9→0 and carries into tens. The digits always equal `minutes` in decimal. No divider is used.
- **Quiz rule:** a modulo counter runs from 0 to `QUIZ_PERIOD-1` and advances on each tick. `quiz_due` pulses with the tick that wraps it to 0, unless that tick also reaches `MAX_MIN`; DONE has priority and no quiz is raised.
- **Width:** `minutes` never exceeds `MAX_MIN`, so there is no 8-bit wrap. The prescaler is `$clog2(TICK_CYCLES)` bits wide.

## Timing
- All outputs are registered and change only on the rising edge of `Clk`, except on asynchronous reset.
- From the `start` sample edge to the first `tick` is exactly `TICK_CYCLES` cycles, when there is no pause.
- `minutes`, `min_tens`, `min_ones`, `tick` and `quiz_due` update on the same edge.
- `tick` and `quiz_due` are high for exactly one cycle.
- A pause of P cycles delays every subsequent tick by exactly P cycles.
- `running` and `class_over` follow the state with zero added latency: both are decoded from the state register.
- Reset deasserting mid-minute starts cleanly in IDLE; no stale prescaler count survives.

## Structure
- **Shared package `fpsr_pkg`:** FSM state encoding (IDLE, RUN, PAUSE, DONE) and the default constants for `TICK_CYCLES`, `MAX_MIN` and `QUIZ_PERIOD`.
- **Sub-module `bcd_digit_counter`:** a mod-10 digit with enable, synchronous clear, carry-out and async active-low reset. Two instances are chained for tens and ones.
- **Top-level integration:** the top instantiates `lecture_timer` in place of its inline divider and feeds `minutes` to the game FSM. `min_tens` and `min_ones` go to SSD1 and SSD0.

## Test plan
All scenarios use `TICK_CYCLES=4`, `MAX_MIN=6`, `QUIZ_PERIOD=3`.
- Reset, then a `start` pulse: `tick` occurs 4 cycles later, `minutes=1`, `running=1`. Ticks recur every 4 cycles.
- Run to the end: `quiz_due` pulses with the tick that gives `minutes=3`. At `minutes=6` `class_over=1` with no `quiz_due`, and 20 more idle cycles leave `minutes=6`.
- Pause for 10 cycles when the prescaler is at 2: `minutes` holds, and the next `tick` arrives exactly 12 cycles after pause assertion.
- `pause` asserted on the terminal-count cycle: no increment that cycle. After release the tick arrives 1 cycle later.
- `clear` together with `start`, and `clear` while in DONE: next cycle state = IDLE, all outputs = 0, no tick.
- Async `Reset_n` low mid-minute at `minutes=4`: outputs go to 0 immediately. After `start` the first tick arrives at the full 4-cycle latency.
- BCD check with `MAX_MIN=12`, `TICK_CYCLES=2`: at `minutes=10`, `min_tens=1` and `min_ones=0`.
